// File: rtl/fmdll_pkg.sv
// Shared types and code constants for the DCDL code controller.
package fmdll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAR_SETTLE,
    SAR_DECIDE,
    TRK_SETTLE,
    TRK_DECIDE
  } dcdl_ctrl_state_t;

  localparam logic [9:0] CODE_MID = 10'h200;
  localparam logic [9:0] CODE_MAX = 10'h3FF;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags when the post-update settle wait has elapsed.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         CLK_exit,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK_exit) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Flag on the last waiting cycle so the decide state is entered exactly
  // 'value' edges after the load, making the next edge the first acceptable one.
  assign done = (cnt <= W'(1));

endmodule

// File: rtl/dcdl_code_ctrl.sv
// DCDL delay-code controller: SAR coarse search, then +/-1 bang-bang tracking
// with lock detection on alternating decisions.
module dcdl_code_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W   = 10,
  parameter int SETTLE   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic              CLK_exit,
  input  logic              rst,
  input  logic              start,
  input  logic              pd_valid,
  input  logic              lead,
  output logic [CODE_W-1:0] Q,
  output logic              busy,
  output logic              lock,
  output logic              err
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam logic [CODE_W-1:0] Q_MID    = CODE_W'(CODE_MID);
  localparam logic [CODE_W-1:0] Q_MAX    = CODE_W'(CODE_MAX);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
  localparam logic [3:0]        LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [3:0]        SETTLE_V = 4'(SETTLE);

  dcdl_ctrl_state_t state, state_n;
  logic [CODE_W-1:0] q_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [3:0]        acnt, acnt_n;
  logic              busy_n, lock_n, err_n;
  logic              prev_dir, prev_dir_n;
  logic              have_prev, have_prev_n;
  logic              load;
  logic              settled;

  settle_timer #(.W(4)) u_settle (
    .CLK_exit (CLK_exit),
    .rst      (rst),
    .load     (load),
    .value    (SETTLE_V),
    .done     (settled)
  );

  always_ff @(posedge CLK_exit) begin
    if (rst) begin
      state     <= IDLE;
      Q         <= Q_MID;
      idx       <= IDX_TOP;
      busy      <= 1'b0;
      lock      <= 1'b0;
      err       <= 1'b0;
      acnt      <= '0;
      prev_dir  <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      state     <= state_n;
      Q         <= q_n;
      idx       <= idx_n;
      busy      <= busy_n;
      lock      <= lock_n;
      err       <= err_n;
      acnt      <= acnt_n;
      prev_dir  <= prev_dir_n;
      have_prev <= have_prev_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = Q;
    idx_n       = idx;
    busy_n      = busy;
    lock_n      = lock;
    err_n       = err;
    acnt_n      = acnt;
    prev_dir_n  = prev_dir;
    have_prev_n = have_prev;
    load        = 1'b0;

    if (start) begin
      state_n     = SAR_SETTLE;
      q_n         = Q_MID;
      idx_n       = IDX_TOP;
      busy_n      = 1'b1;
      lock_n      = 1'b0;
      err_n       = 1'b0;
      acnt_n      = '0;
      have_prev_n = 1'b0;
      load        = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        SAR_SETTLE: if (settled) state_n = SAR_DECIDE;
        SAR_DECIDE: begin
          if (pd_valid) begin
            load = 1'b1;
            if (!lead) q_n[idx] = 1'b0;
            if (idx != '0) begin
              q_n[idx - 1'b1] = 1'b1;
              idx_n           = idx - 1'b1;
              state_n         = SAR_SETTLE;
            end else begin
              busy_n  = 1'b0;
              state_n = TRK_SETTLE;
            end
          end
        end
        TRK_SETTLE: if (settled) state_n = TRK_DECIDE;
        TRK_DECIDE: begin
          if (pd_valid) begin
            load    = 1'b1;
            state_n = TRK_SETTLE;
            if (lead) begin
              if (Q == Q_MAX) err_n = 1'b1;
              else            q_n   = Q + 1'b1;
            end else begin
              if (Q == '0) err_n = 1'b1;
              else         q_n   = Q - 1'b1;
            end
            // A held step at the rails still counts as a decision in its direction.
            if (!have_prev) begin
              acnt_n = '0;
            end else if (lead != prev_dir) begin
              if (acnt != LOCK_MAX) acnt_n = acnt + 1'b1;
              if (acnt >= LOCK_MAX - 4'd1) lock_n = 1'b1;
            end else begin
              acnt_n = '0;
              lock_n = 1'b0;
            end
            prev_dir_n  = lead;
            have_prev_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcdl_code_ctrl.sv
// Self-checking bench for dcdl_code_ctrl driven by a behavioural phase-detector model.
module tb_dcdl_code_ctrl;

  localparam int CODE_W   = 10;
  localparam int SETTLE   = 4;
  localparam int LOCK_CNT = 8;
  localparam logic [9:0] MID = 10'h200;

  logic CLK_exit = 1'b0;
  logic rst      = 1'b1;
  logic start    = 1'b0;
  logic pd_valid = 1'b0;
  logic lead     = 1'b0;
  logic [CODE_W-1:0] Q;
  logic busy, lock, err;

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb[$];  // {err, lock, Q}
  logic        model_on = 1'b0;
  logic [9:0]  target   = '0;

  logic [9:0] m_q = '0;
  logic m_prev = 1'b0, m_have_prev = 1'b0, m_lock = 1'b0, m_err = 1'b0;
  int   m_acnt = 0;

  always #5 CLK_exit = ~CLK_exit;

  dcdl_code_ctrl #(
    .CODE_W   (CODE_W),
    .SETTLE   (SETTLE),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .CLK_exit (CLK_exit),
    .rst      (rst),
    .start    (start),
    .pd_valid (pd_valid),
    .lead     (lead),
    .Q        (Q),
    .busy     (busy),
    .lock     (lock),
    .err      (err)
  );

  task automatic tick();
    @(negedge CLK_exit);
    if (model_on) lead = (Q <= target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [9:0] sar_result(input logic [9:0] t);
    logic [9:0] qe;
    qe = '0;
    for (int i = 9; i >= 0; i--) begin
      qe[i] = 1'b1;
      if (qe > t) qe[i] = 1'b0;
    end
    return qe;
  endfunction

  task automatic model_decide();
    logic d;
    d = (m_q <= target);
    if (d) begin
      if (m_q == 10'h3FF) m_err = 1'b1; else m_q = m_q + 10'd1;
    end else begin
      if (m_q == 10'h000) m_err = 1'b1; else m_q = m_q - 10'd1;
    end
    if (!m_have_prev) m_acnt = 0;
    else if (d != m_prev) begin
      if (m_acnt < LOCK_CNT) m_acnt++;
      if (m_acnt == LOCK_CNT) m_lock = 1'b1;
    end else begin
      m_acnt = 0;
      m_lock = 1'b0;
    end
    m_prev = d;
    m_have_prev = 1'b1;
  endtask

  task automatic track(input int n);
    logic [10:0] last;
    logic [11:0] exp;
    int waited;
    for (int k = 0; k < n; k++) begin
      model_decide();
      sb.push_back({m_err, m_lock, m_q});
      last = {err, Q};
      waited = 0;
      while ({err, Q} === last && waited < 4 * (SETTLE + 1)) begin
        tick();
        waited++;
      end
      exp = sb.pop_front();
      checks++;
      if ({err, lock, Q} !== exp) begin
        failures++;
        $display("FAIL track_step: Q/lock/err got %h/%b/%b expected %h/%b/%b (waited %0d)",
                 Q, lock, err, exp[9:0], exp[10], exp[11], waited);
      end
    end
  endtask

  task automatic run_sar(input string name);
    int bc;
    logic [11:0] exp;
    sb.push_back({2'b00, sar_result(target)});
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      tick();
    end
    checks++;
    if (bc != CODE_W * (SETTLE + 1)) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d cycles expected %0d", name, bc, CODE_W * (SETTLE + 1));
    end
    exp = sb.pop_front();
    checks++;
    if ({err, lock, Q} !== exp) begin
      failures++;
      $display("FAIL %s_result: Q/lock/err got %h/%b/%b expected %h/%b/%b",
               name, Q, lock, err, exp[9:0], exp[10], exp[11]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; model_on = 1'b0; pd_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 1) rst = 1'b0;
      checks++;
      if ({Q, busy, lock, err} !== {MID, 3'b000}) begin
        failures++;
        $display("FAIL reset_idle[%0d]: Q/busy/lock/err got %h/%b/%b/%b expected 200/0/0/0",
                 i, Q, busy, lock, err);
      end
    end
  endtask

  task automatic test_sar_converge();
    target = 10'h15A; model_on = 1'b1; pd_valid = 1'b1;
    pulse_start();
    run_sar("sar_converge");
    m_q = sar_result(target); m_have_prev = 1'b0; m_acnt = 0; m_lock = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_tracking_lock();
    int lock_at;
    lock_at = -1;
    for (int k = 0; k < 12; k++) begin
      track(1);
      if (lock && lock_at < 0) lock_at = k + 1;
    end
    checks++;
    if (lock_at != LOCK_CNT + 1) begin
      failures++;
      $display("FAIL lock_rise_decision: got %0d expected %0d", lock_at, LOCK_CNT + 1);
    end
    target = 10'h160;
    lead = (Q <= target);
    track(2);
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL lock_clear_same_dir: got %b expected 0", lock);
    end
    track(28);
    checks++;
    if (!(Q == 10'h160 || Q == 10'h161) || lock !== 1'b1) begin
      failures++;
      $display("FAIL relock_160: Q/lock got %h/%b expected 160or161/1", Q, lock);
    end
  endtask

  task automatic test_settle_gating();
    logic [9:0] qe;
    int idx;
    logic dec;
    model_on = 1'b0; pd_valid = 1'b0;
    pulse_start();
    qe = MID; idx = 9;
    for (int r = 0; r < 4; r++) begin
      dec = (r % 2 == 0);
      for (int s = 1; s <= SETTLE; s++) begin
        pd_valid = (s == 1 || s == SETTLE); lead = 1'b0;
        tick();
        checks++;
        if (Q !== qe || busy !== 1'b1) begin
          failures++;
          $display("FAIL settle_ignore[r%0d s%0d]: Q/busy got %h/%b expected %h/1", r, s, Q, busy, qe);
        end
      end
      pd_valid = 1'b1; lead = dec;
      tick();
      pd_valid = 1'b0;
      if (!dec) qe[idx] = 1'b0;
      qe[idx-1] = 1'b1;
      idx--;
      sb.push_back({2'b00, qe});
      checks++;
      if ({err, lock, Q} !== sb[0]) begin
        failures++;
        $display("FAIL settle_accept[r%0d]: Q got %h expected %h", r, Q, sb[0][9:0]);
      end
      void'(sb.pop_front());
    end
  endtask

  task automatic test_abort();
    logic [9:0] qp;
    target = 10'h2C5; model_on = 1'b1; pd_valid = 1'b1;
    lead = (Q <= target);
    pulse_start();
    repeat (4 * (SETTLE + 1) + 2) tick();
    qp = '0;
    for (int i = 9; i >= 6; i--) begin
      qp[i] = 1'b1;
      if (qp > target) qp[i] = 1'b0;
    end
    qp[5] = 1'b1;
    checks++;
    if (Q !== qp) begin
      failures++;
      $display("FAIL abort_step5_code: Q got %h expected %h", Q, qp);
    end
    pulse_start();
    checks++;
    if ({Q, busy, lock, err} !== {MID, 3'b100}) begin
      failures++;
      $display("FAIL abort_restart: Q/busy/lock/err got %h/%b/%b/%b expected 200/1/0/0", Q, busy, lock, err);
    end
    run_sar("abort_sar");
  endtask

  task automatic wait_err(input string name);
    int w;
    w = 0;
    while (!err && w < 3 * (SETTLE + 1)) begin
      tick();
      w++;
    end
    checks++;
    if ({Q, lock, err} !== {10'h3FF, 2'b01}) begin
      failures++;
      $display("FAIL %s: Q/lock/err got %h/%b/%b expected 3ff/0/1", name, Q, lock, err);
    end
  endtask

  task automatic test_saturation();
    target = 10'h3FF; model_on = 1'b1; pd_valid = 1'b1;
    lead = 1'b1;
    pulse_start();
    run_sar("sat_sar");
    wait_err("sat_first_err");
    repeat (2 * (SETTLE + 1)) tick();
    checks++;
    if ({Q, err} !== {10'h3FF, 1'b1}) begin
      failures++;
      $display("FAIL sat_err_sticky: Q/err got %h/%b expected 3ff/1", Q, err);
    end
    pulse_start();
    checks++;
    if ({Q, busy, err} !== {MID, 2'b10}) begin
      failures++;
      $display("FAIL sat_start_clears_err: Q/busy/err got %h/%b/%b expected 200/1/0", Q, busy, err);
    end
    run_sar("sat_sar2");
    wait_err("sat_second_err");
    m_q = 10'h3FF; m_err = 1'b1; m_have_prev = 1'b1; m_prev = 1'b1; m_acnt = 0; m_lock = 1'b0;
    target = 10'h3FE;
    lead = (Q <= target);
    track(10);
    checks++;
    if ({lock, err} !== 2'b11) begin
      failures++;
      $display("FAIL sat_lock_with_err: lock/err got %b/%b expected 1/1", lock, err);
    end
  endtask

  task automatic test_reset_mid_track();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({Q, busy, lock, err} !== {MID, 3'b000}) begin
      failures++;
      $display("FAIL reset_mid_track: Q/busy/lock/err got %h/%b/%b/%b expected 200/0/0/0", Q, busy, lock, err);
    end
    start = 1'b1;
    tick();
    checks++;
    if ({Q, busy} !== {MID, 1'b0}) begin
      failures++;
      $display("FAIL reset_over_start: Q/busy got %h/%b expected 200/0", Q, busy);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({Q, busy, lock, err} !== {MID, 3'b000}) begin
        failures++;
        $display("FAIL idle_after_reset[%0d]: Q/busy got %h/%b expected 200/0", i, Q, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sar_converge();
    test_tracking_lock();
    test_settle_gating();
    test_abort();
    test_saturation();
    test_reset_mid_track();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
